// File: rtl/fifo_pkg.sv
// Shared definitions for the thresholded FIFO: width helpers and the
// status-flag bundle used inside fifo_thr.
package fifo_pkg;

    // Bits needed to hold an occupancy value in the range 0..depth.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least one bit).
    function automatic int fifo_pw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage array: one synchronous write port and one asynchronous read
// port. Contents are deliberately not reset.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic [AW-1:0]    rd_addr_i,
    output logic [WIDTH-1:0] rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store the incoming word at the write pointer on an accepted write.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fifo_thr.sv
// Synchronous FIFO with occupancy count, almost-full/almost-empty thresholds
// and sticky overflow/underflow flags.
// Build option: define FIFO_THR_FWFT_EN for first-word-fall-through reads
// (head word shown combinationally, o_rd_valid = !empty); otherwise reads are
// registered and o_rd_valid pulses one cycle after each accepted read.
module fifo_thr
    import fifo_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int DEPTH     = 64,
    parameter  int AF_THRESH = DEPTH - 4,
    parameter  int AE_THRESH = 4,
    localparam int CW        = fifo_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic             i_clr_err,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_rd_valid,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty,
    output logic             o_overflow,
    output logic             o_underflow
);

    localparam int             PW       = fifo_pw(DEPTH);
    localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0]  AF_C     = CW'(AF_THRESH);
    localparam logic [CW-1:0]  AE_C     = CW'(AE_THRESH);
    localparam logic [PW-1:0]  LAST_PTR = PW'(DEPTH - 1);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;
    logic             rd_acc;
    logic             wr_acc;
    logic [WIDTH-1:0] head_data;
    fifo_status_t     status;

    // Pointers wrap explicitly so any DEPTH works, not just powers of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (wr_acc),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (i_wr_data),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (head_data)
    );

    // Accept decisions and next-state for pointers, count and sticky errors.
    // Flush suppresses both accepts and error setting; a full FIFO still
    // takes a write when a read frees a slot in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        rd_acc = !i_flush && i_rd_en && (count_q != '0);
        wr_acc = !i_flush && i_wr_en && ((count_q != DEPTH_C) || rd_acc);

        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (rd_acc) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // Setting wins over a simultaneous clear.
        ovf_d = (!i_flush && i_wr_en && !wr_acc) || (ovf_q && !i_clr_err);
        udf_d = (!i_flush && i_rd_en && !rd_acc) || (udf_q && !i_clr_err);
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Status flags decode straight from the registered count.
    always_comb begin
        status              = '0;
        status.full         = (count_q == DEPTH_C);
        status.empty        = (count_q == '0);
        status.almost_full  = (count_q >= AF_C);
        status.almost_empty = (count_q <= AE_C);
        status.overflow     = ovf_q;
        status.underflow    = udf_q;
    end

    assign o_count        = count_q;
    assign o_full         = status.full;
    assign o_empty        = status.empty;
    assign o_almost_full  = status.almost_full;
    assign o_almost_empty = status.almost_empty;
    assign o_overflow     = status.overflow;
    assign o_underflow    = status.underflow;

`ifdef FIFO_THR_FWFT_EN
    // Head word falls through; a read simply advances the pointer.
    assign o_rd_data  = head_data;
    assign o_rd_valid = !status.empty;
`else
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    // Capture the head word on an accepted read; hold it otherwise.
    always_comb begin
        rd_data_d  = rd_acc ? head_data : rd_data_q;
        rd_valid_d = rd_acc;
    end

    // Registered read port; flush clears valid because rd_acc is low then.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
`endif

endmodule

// File: tb/tb_fifo_thr.sv
// Scoreboard bench for fifo_thr: a DEPTH=4 instance for the main checks and
// a DEPTH=5 instance for the non-power-of-two streaming case.
module tb_fifo_thr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, wr_en, rd_en, clr_err;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       rd_valid, full, empty, afull, aempty, ovf, udf;
    logic [2:0] count;

    logic       wr_en5, rd_en5;
    logic [7:0] wr_data5, rd_data5;
    logic       rd_valid5, full5, empty5, afull5, aempty5, ovf5, udf5;
    logic [2:0] count5;

    logic [7:0] mq[$], exp_q[$], mq5[$], exp5[$];
    logic       exp_ovf, exp_udf;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    fifo_thr #(.WIDTH(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_wr_en(wr_en),
        .i_wr_data(wr_data), .i_rd_en(rd_en), .i_clr_err(clr_err),
        .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_count(count),
        .o_full(full), .o_empty(empty), .o_almost_full(afull),
        .o_almost_empty(aempty), .o_overflow(ovf), .o_underflow(udf)
    );

    fifo_thr #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .i_flush(1'b0), .i_wr_en(wr_en5),
        .i_wr_data(wr_data5), .i_rd_en(rd_en5), .i_clr_err(1'b0),
        .o_rd_data(rd_data5), .o_rd_valid(rd_valid5), .o_count(count5),
        .o_full(full5), .o_empty(empty5), .o_almost_full(afull5),
        .o_almost_empty(aempty5), .o_overflow(ovf5), .o_underflow(udf5)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Compare count and every flag of the DEPTH=4 DUT against the model.
    task automatic check_state(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"},   32'(count),  32'(n));
        chk({tag, ".full"},    32'(full),   32'(n == 4));
        chk({tag, ".empty"},   32'(empty),  32'(n == 0));
        chk({tag, ".afull"},   32'(afull),  32'(n >= 3));
        chk({tag, ".aempty"},  32'(aempty), 32'(n <= 1));
        chk({tag, ".ovf"},     32'(ovf),    32'(exp_ovf));
        chk({tag, ".udf"},     32'(udf),    32'(exp_udf));
    endtask

    // One clock of stimulus on the DEPTH=4 DUT; called just after a rising edge.
    task automatic step(input string tag, input logic wr, input logic [7:0] d,
                        input logic rd, input logic fl, input logic clr);
        bit rok, wok;
        wr_en = wr; wr_data = d; rd_en = rd; flush = fl; clr_err = clr;
        rok = rd && !fl && (mq.size() != 0);
        wok = wr && !fl && ((mq.size() != 4) || rok);
        if (fl) mq.delete();
        else begin
            if (rok) exp_q.push_back(mq.pop_front());
            if (wok) mq.push_back(d);
        end
        exp_ovf = (wr && !fl && !wok) || (exp_ovf && !clr);
        exp_udf = (rd && !fl && !rok) || (exp_udf && !clr);
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
        check_state(tag);
    endtask

    // Read-data monitors: pop the expected word whenever the DUT presents one.
`ifdef FIFO_THR_FWFT_EN
    always @(negedge clk) begin
        if (rst_n && rd_en && rd_valid) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 32'(rd_data), 32'hFFFF);
            else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        if (rst_n && rd_en5 && rd_valid5) begin
            if (exp5.size() == 0) chk("rd5_unexpected", 32'(rd_data5), 32'hFFFF);
            else chk("rd5_data", 32'(rd_data5), 32'(exp5.pop_front()));
        end
    end
`else
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 32'(rd_data), 32'hFFFF);
            else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
        if (rst_n && rd_valid5) begin
            if (exp5.size() == 0) chk("rd5_unexpected", 32'(rd_data5), 32'hFFFF);
            else chk("rd5_data", 32'(rd_data5), 32'(exp5.pop_front()));
        end
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_ovf = 0; exp_udf = 0;
        flush = 0; clr_err = 0; wr_data = 8'h99;
        wr_en5 = 0; rd_en5 = 0; wr_data5 = 0;
        // Reset with write and read requested: reset must win.
        rst_n = 0; wr_en = 1; rd_en = 1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1; wr_en = 0; rd_en = 0;
        check_state("reset");
        chk("reset.rd_valid", 32'(rd_valid), 32'd0);
`ifndef FIFO_THR_FWFT_EN
        chk("reset.rd_data", 32'(rd_data), 32'd0);
`endif
        chk("reset.count5", 32'(count5), 32'd0);

        // Underflow on empty read, then clear.
        step("udf_set", 0, 8'h00, 1, 0, 0);
        chk("udf_set.rd_valid", 32'(rd_valid), 32'd0);
        chk("udf_set.hand", 32'(udf), 32'd1);
        step("udf_clr", 0, 8'h00, 0, 0, 1);
        chk("udf_clr.hand", 32'(udf), 32'd0);

        // Fill to full, then overflow attempt.
        step("fill1", 1, 8'h11, 0, 0, 0);
        step("fill2", 1, 8'h22, 0, 0, 0);
        step("fill3", 1, 8'h33, 0, 0, 0);
        chk("fill3.afull_hand", 32'(afull), 32'd1);
        step("fill4", 1, 8'h44, 0, 0, 0);
        chk("fill4.full_hand", 32'(full), 32'd1);
        step("ovf", 1, 8'h55, 0, 0, 0);
        chk("ovf.hand", 32'(ovf), 32'd1);
        chk("ovf.count_hand", 32'(count), 32'd4);
        step("ovf_clr", 0, 8'h00, 0, 0, 1);

        // Write into full FIFO together with a read.
        step("full_wr_rd", 1, 8'hA5, 1, 0, 0);
        chk("full_wr_rd.count_hand", 32'(count), 32'd4);

        // Alternating reads and writes across several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            step("alt_rd", 0, 8'h00, 1, 0, 0);
            step("alt_wr", 1, 8'(8'h60 + i), 0, 0, 0);
        end
        repeat (4) step("drain", 0, 8'h00, 1, 0, 0);
        step("idle", 0, 8'h00, 0, 0, 0);

        // Flush overrides same-cycle write and read.
        step("pre_fl1", 1, 8'h01, 0, 0, 0);
        step("pre_fl2", 1, 8'h02, 0, 0, 0);
        step("pre_fl3", 1, 8'h03, 0, 0, 0);
        step("flush", 1, 8'hEE, 1, 1, 0);
        chk("flush.count_hand", 32'(count), 32'd0);
        chk("flush.rd_valid", 32'(rd_valid), 32'd0);
        step("post_fl_wr", 1, 8'h7E, 0, 0, 0);
        step("post_fl_rd", 0, 8'h00, 1, 0, 0);
`ifdef FIFO_THR_FWFT_EN
        step("fwft_wr", 1, 8'h3C, 0, 0, 0);
        chk("fwft.rd_valid", 32'(rd_valid), 32'd1);
        chk("fwft.rd_data", 32'(rd_data), 32'h3C);
        step("fwft_pop", 0, 8'h00, 1, 0, 0);
        chk("fwft_pop.rd_valid", 32'(rd_valid), 32'd0);
`else
        chk("post_fl_rd.data_hand", 32'(rd_data), 32'h7E);
        step("pulse", 0, 8'h00, 0, 0, 0);
        chk("pulse.rd_valid", 32'(rd_valid), 32'd0);
        chk("pulse.rd_data_hold", 32'(rd_data), 32'h7E);
`endif

        // DEPTH=5: fill, stream at full occupancy, then drain; 12 words.
        for (int i = 0; i < 17; i++) begin
            bit rok5, wok5;
            wr_en5 = (i < 12); wr_data5 = 8'(8'hC0 + i); rd_en5 = (i >= 5);
            rok5 = rd_en5 && (mq5.size() != 0);
            wok5 = wr_en5 && ((mq5.size() != 5) || rok5);
            if (rok5) exp5.push_back(mq5.pop_front());
            if (wok5) mq5.push_back(wr_data5);
            @(posedge clk); #1;
            wr_en5 = 0; rd_en5 = 0;
            chk("d5.count", 32'(count5), 32'(mq5.size()));
            chk("d5.count_max", 32'(count5 <= 3'd5), 32'd1);
        end
        chk("d5.ovf", 32'(ovf5), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        chk("drained", 32'(exp_q.size()), 32'd0);
        chk("drained5", 32'(exp5.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
